approx_adder_err_sweeper: RTL
=============================

Name: approx_adder_err_sweeper

Overview:
Self-sequencing characterization controller for the 16-bit approximate adders (fba_adder, eta2_adder) against the exact cra_adder reference.
- Generates pseudo-random operand pairs and drives them to one approximate adder and the exact adder in parallel.
- Compares the two results every cycle and accumulates error statistics over a programmed number of samples.
- Sits beside the adder instances in the approx_adders characterization harness, with a start/done handshake.

Parameters:
CNT_W, 16, width of sample counter, num_samples and err_count.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
num_samples  input  CNT_W  samples per sweep; sampled on the accepted start.
seed_a  input  16  LFSR seed for operand A; sampled on start.
seed_b  input  16  LFSR seed for operand B; sampled on start.
op_a  output  16  registered operand A driven to both adders.
op_b  output  16  registered operand B driven to both adders.
y_apx  input  16  approximate adder sum, combinational from op_a/op_b.
cout_apx  input  1  approximate adder carry-out.
y_ext  input  16  exact adder sum.
cout_ext  input  1  exact adder carry-out.
busy  output  1  high in LOAD and RUN.
done  output  1  one-cycle pulse when the sweep completes.
err_count  output  CNT_W  number of samples where {cout,Y} differ.
max_ed  output  17  maximum error distance seen.
sum_ed  output  CNT_W+17  sum of error distances.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - op_a=op_b=0, busy=0, done=0.
  - err_count=0, max_ed=0, sum_ed=0, counter=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE/DONE, start=1:
  - Latch num_samples.
  - Load LFSR_A from seed_a and LFSR_B from seed_b. A zero seed is replaced by 16'hACE1.
  - Drive op_a/op_b with the loaded seed values.
  - Clear err_count, max_ed, sum_ed and the counter.
  - Go to LOAD.
  - Exception: if num_samples==0, go straight to DONE with stats cleared.
- LOAD: one cycle, operand settle. Next state is RUN.
- RUN, every cycle:
  - Form E = {cout_ext,y_ext} and P = {cout_apx,y_apx}, 17-bit unsigned.
  - ed = |E-P|.
  - If ed!=0, err_count+=1.
  - max_ed = max(max_ed,ed).
  - sum_ed += ed, zero-extended.
  - Advance both LFSRs.
  - op_a/op_b take the new LFSR values.
  - counter+=1.
- LFSRs: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Shift right.
  - If the pre-shift LSB is 1, XOR the shifted value with the mask.
- Sample indexing: sample 0 is the seed pair. Sample i is the pair after i advances.
- RUN exit: the cycle where counter==num_samples-1 accumulates the last sample, then goes to DONE.
  - done=1 for exactly that following cycle.
  - busy=0 in DONE.
- DONE: statistics and op_a/op_b hold until the next accepted start.
  - done is only a pulse: it drops after one cycle even if the block stays in DONE.
- Latency: done asserts num_samples+2 cycles after the start edge (num_samples>0). For num_samples==0 it asserts 1 cycle after.
- start while busy: ignored, with no effect on state or statistics.
- Widths: err_count cannot overflow, since it is at most num_samples. sum_ed is sized to never overflow (max ed 2^17-1 times 2^CNT_W-1 samples).
- rst mid-sweep: immediate abort to reset values. No done pulse.
- Inputs y_*/cout_* are sampled only in RUN and ignored in other states.

Optional Feature:
Macro FIRST_ERR_CAPTURE_EN.
- With the macro defined, three extra outputs are added:
  - first_err_valid (1)
  - first_err_a (16)
  - first_err_b (16)
- On the first RUN cycle with ed!=0, the block captures op_a/op_b and sets first_err_valid.
- Capture is frozen until the next accepted start or rst, both of which clear all three outputs to 0.
- Without the macro, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
1. Bench ties y_apx/cout_apx to the exact adder outputs; seeds 0x1234/0x5678, num_samples=100 -> done at cycle 102 after start, err_count=0, max_ed=0, sum_ed=0.
2. Stub approximate result = exact-5 when op_a[0]==1, else exact; num_samples=1000 -> err_count equals the bench-model count of odd op_a, max_ed=5, sum_ed=5*err_count.
3. seed_a=0, seed_b=0, num_samples=1 -> op_a=op_b=16'hACE1 during LOAD/RUN, one-cycle done; with the real fba_adder, ed matches the bench golden model for 0xACE1+0xACE1.
4. num_samples=0 -> done one cycle after start, busy never high, all stats 0.
5. Pulse start again at RUN cycle 3 -> ignored, sweep completes unchanged. Assert rst at RUN cycle 10 -> all outputs 0 immediately, no done. A new start then runs normally.
6. With FIRST_ERR_CAPTURE_EN defined and the stub from scenario 2 -> first_err_a equals the first odd op_a in the LFSR sequence, first_err_valid=1 and held through DONE, cleared by the next start.

Source files
------------

// File: rtl/approx_adder_err_sweeper.sv
// Sweeps LFSR operand pairs through an approximate and an exact 16-bit adder and accumulates error stats.
// Optional FIRST_ERR_CAPTURE_EN macro adds capture of the first mismatching operand pair.
module approx_adder_err_sweeper #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic [15:0]          seed_a,
  input  logic [15:0]          seed_b,
  output logic [15:0]          op_a,
  output logic [15:0]          op_b,
  input  logic [15:0]          y_apx,
  input  logic                 cout_apx,
  input  logic [15:0]          y_ext,
  input  logic                 cout_ext,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_count,
  output logic [16:0]          max_ed,
  output logic [CNT_W+16:0]    sum_ed
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic                 first_err_valid,
  output logic [15:0]          first_err_a,
  output logic [15:0]          first_err_b
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [15:0]      LFSR_MASK  = 16'hB400;
  localparam logic [15:0]      ZERO_SEED  = 16'hACE1;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  // An all-zero Galois LFSR would lock up, so a zero seed is substituted.
  function automatic logic [15:0] seed_fix(input logic [15:0] v);
    seed_fix = (v == 16'h0000) ? ZERO_SEED : v;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [15:0]         op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CNT_W-1:0]    nsamp_q, nsamp_d, cnt_q, cnt_d, err_q, err_d;
  logic [16:0]         max_q, max_d;
  logic [CNT_W+16:0]   sum_q, sum_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [16:0]         e_s, p_s, ed_s;
  logic                start_ok_s;
`ifdef FIRST_ERR_CAPTURE_EN
  logic                fe_v_q, fe_v_d;
  logic [15:0]         fe_a_q, fe_a_d, fe_b_q, fe_b_d;
`endif

  assign e_s        = {cout_ext, y_ext};
  assign p_s        = {cout_apx, y_apx};
  assign ed_s       = (e_s >= p_s) ? (e_s - p_s) : (p_s - e_s);
  assign start_ok_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    nsamp_d = nsamp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    max_d   = max_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
    fe_v_d  = fe_v_q;
    fe_a_d  = fe_a_q;
    fe_b_d  = fe_b_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok_s) begin
          nsamp_d = num_samples;
          op_a_d  = seed_fix(seed_a);
          op_b_d  = seed_fix(seed_b);
          cnt_d   = CNT_ZERO;
          err_d   = CNT_ZERO;
          max_d   = 17'd0;
          sum_d   = {(CNT_W+17){1'b0}};
`ifdef FIRST_ERR_CAPTURE_EN
          fe_v_d  = 1'b0;
          fe_a_d  = 16'h0000;
          fe_b_d  = 16'h0000;
`endif
          if (num_samples == CNT_ZERO) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (ed_s != 17'd0) begin
          err_d = err_q + CNT_ONE;
        end else begin
          err_d = err_q;
        end
        if (ed_s > max_q) begin
          max_d = ed_s;
        end else begin
          max_d = max_q;
        end
        sum_d  = sum_q + {{CNT_W{1'b0}}, ed_s};
`ifdef FIRST_ERR_CAPTURE_EN
        if ((ed_s != 17'd0) && !fe_v_q) begin
          fe_v_d = 1'b1;
          fe_a_d = op_a_q;
          fe_b_d = op_b_q;
        end else begin
          fe_v_d = fe_v_q;
        end
`endif
        op_a_d = lfsr_step(op_a_q);
        op_b_d = lfsr_step(op_b_q);
        cnt_d  = cnt_q + CNT_ONE;
        // nsamp_q is never zero here: a zero request bypasses RUN entirely.
        if (cnt_q == (nsamp_q - CNT_ONE)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
  end

  // State, operand and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= 16'h0000;
      op_b_q  <= 16'h0000;
      nsamp_q <= CNT_ZERO;
      cnt_q   <= CNT_ZERO;
      err_q   <= CNT_ZERO;
      max_q   <= 17'd0;
      sum_q   <= {(CNT_W+17){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
      fe_v_q  <= 1'b0;
      fe_a_q  <= 16'h0000;
      fe_b_q  <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      nsamp_q <= nsamp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIRST_ERR_CAPTURE_EN
      fe_v_q  <= fe_v_d;
      fe_a_q  <= fe_a_d;
      fe_b_q  <= fe_b_d;
`endif
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign max_ed    = max_q;
  assign sum_ed    = sum_q;
`ifdef FIRST_ERR_CAPTURE_EN
  assign first_err_valid = fe_v_q;
  assign first_err_a     = fe_a_q;
  assign first_err_b     = fe_b_q;
`endif

endmodule
